// File: rtl/decode.sv
// Instruction decode stage: field decode, 32x32 register file with write bypass,
// load-use hazard detection, and the ID_EX pipeline register.
module decode (
   input  logic         clock,
   input  logic         reset,
   input  logic         if_valid,
   input  logic [63:0]  IF_ID,
   input  logic         flush,
   input  logic         wb_en,
   input  logic [4:0]   wb_addr,
   input  logic [31:0]  wb_data,
   output logic         stall,
   output logic         ex_valid,
   output logic [140:0] ID_EX
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   logic [31:0]  rf_q [32];
   logic         ex_valid_q, ex_valid_d;
   logic [140:0] id_ex_q, id_ex_d;

   logic [31:0] pc, ins;
   logic [5:0]  opcode;
   logic [4:0]  rs, rt, rd, dest;
   logic [31:0] imm, rs_data, rt_data;
   logic [7:0]  ctrl;
   logic        use_rs, use_rt, hazard;
   logic [4:0]  ex_dest;

   assign pc     = IF_ID[63:32];
   assign ins    = IF_ID[31:0];
   assign opcode = ins[31:26];
   assign rs     = ins[25:21];
   assign rt     = ins[20:16];
   assign rd     = ins[15:11];

   always_comb begin
      ctrl   = 8'h00;
      dest   = 5'd0;
      use_rs = 1'b0;
      use_rt = 1'b0;
      case (opcode)
         OP_RTYPE: begin ctrl[7] = 1'b1; dest = rd; use_rs = 1'b1; use_rt = 1'b1; end
         OP_ADDI:  begin ctrl[7] = 1'b1; ctrl[3] = 1'b1; dest = rt; use_rs = 1'b1; end
         OP_LW: begin
            ctrl[7] = 1'b1; ctrl[6] = 1'b1; ctrl[4] = 1'b1; ctrl[3] = 1'b1;
            dest = rt; use_rs = 1'b1;
         end
         OP_SW:    begin ctrl[5] = 1'b1; ctrl[3] = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
         OP_BEQ:   begin ctrl[2] = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
         OP_J:     ctrl[1] = 1'b1;
         default:  ctrl[0] = 1'b1;
      endcase
      // Writes to r0 are architecturally void, so never advertise them downstream.
      if (dest == 5'd0) ctrl[7] = 1'b0;
   end

   assign imm = (opcode == OP_J) ? {6'd0, ins[25:0]} : {{16{ins[15]}}, ins[15:0]};

   // Same-cycle writeback is forwarded so decode never reads a stale value.
   assign rs_data = (rs == 5'd0) ? 32'd0 :
                    (wb_en && (wb_addr == rs)) ? wb_data : rf_q[rs];
   assign rt_data = (rt == 5'd0) ? 32'd0 :
                    (wb_en && (wb_addr == rt)) ? wb_data : rf_q[rt];

   assign ex_dest = id_ex_q[12:8];
   assign hazard  = (use_rs && (rs == ex_dest)) || (use_rt && (rt == ex_dest));
   assign stall   = reset && ex_valid_q && id_ex_q[6] && (ex_dest != 5'd0) &&
                    if_valid && !flush && hazard;

   always_comb begin
      ex_valid_d = 1'b0;
      id_ex_d    = '0;
      if (if_valid && !flush && !stall) begin
         ex_valid_d = 1'b1;
         id_ex_d    = {pc, rs_data, rt_data, imm, dest, ctrl};
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ex_valid_q <= 1'b0;
         id_ex_q    <= '0;
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else begin
         ex_valid_q <= ex_valid_d;
         id_ex_q    <= id_ex_d;
         if (wb_en && (wb_addr != 5'd0)) rf_q[wb_addr] <= wb_data;
      end
   end

   assign ex_valid = ex_valid_q;
   assign ID_EX    = id_ex_q;

endmodule

// File: tb/tb_decode.sv
// Bench for decode: directed literal cases plus randomized traffic compared
// every cycle against a behavioural model of the decode stage.
module tb_decode;

   logic         clock = 1'b0;
   logic         reset;
   logic         if_valid;
   logic [63:0]  IF_ID;
   logic         flush;
   logic         wb_en;
   logic [4:0]   wb_addr;
   logic [31:0]  wb_data;
   logic         stall;
   logic         ex_valid;
   logic [140:0] ID_EX;

   decode dut (
      .clock(clock), .reset(reset), .if_valid(if_valid), .IF_ID(IF_ID),
      .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .stall(stall), .ex_valid(ex_valid), .ID_EX(ID_EX)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   logic [31:0]  m_rf [32];
   logic         m_valid;
   logic [140:0] m_idex;
   logic         m_stall = 1'b0;

   task automatic chk(input string name, input logic [140:0] act, input logic [140:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] r_ins(input int s, input int t, input int d);
      logic [31:0] w;
      w = {6'h00, 5'(s), 5'(t), 5'(d), 5'd0, 6'h20};
      return w;
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op, input int s, input int t, input logic [15:0] im);
      logic [31:0] w;
      w = {op, 5'(s), 5'(t), im};
      return w;
   endfunction

   function automatic logic [31:0] mread(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (wb_en && wb_addr == idx) return wb_data;
      return m_rf[idx];
   endfunction

   function automatic logic [140:0] model_decode(input logic [63:0] f);
      logic [31:0] w, imm;
      logic [5:0]  op;
      logic [7:0]  c;
      logic [4:0]  d;
      w = f[31:0];
      op = w[31:26];
      d = 5'd0;
      case (op)
         6'h00: begin c = 8'h80; d = w[15:11]; end
         6'h08: begin c = 8'h88; d = w[20:16]; end
         6'h23: begin c = 8'hD8; d = w[20:16]; end
         6'h2B: c = 8'h28;
         6'h04: c = 8'h04;
         6'h02: c = 8'h02;
         default: c = 8'h01;
      endcase
      if (d == 5'd0) c[7] = 1'b0;
      imm = (op == 6'h02) ? {6'd0, w[25:0]} : {{16{w[15]}}, w[15:0]};
      return {f[63:32], mread(w[25:21]), mread(w[20:16]), imm, d, c};
   endfunction

   function automatic bit reads_reg(input logic [31:0] w, input logic [4:0] r);
      case (w[31:26])
         6'h00, 6'h2B, 6'h04: return (w[25:21] == r) || (w[20:16] == r);
         6'h08, 6'h23:        return (w[25:21] == r);
         default:             return 1'b0;
      endcase
   endfunction

   function automatic logic model_stall();
      return reset && m_valid && m_idex[6] && (m_idex[12:8] != 5'd0) &&
             if_valid && !flush && reads_reg(IF_ID[31:0], m_idex[12:8]);
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_valid = 1'b0;
         m_idex  = '0;
         for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      end else begin
         if (if_valid && !flush && !model_stall()) begin
            m_valid = 1'b1;
            m_idex  = model_decode(IF_ID);
         end else begin
            m_valid = 1'b0;
            m_idex  = '0;
         end
         if (wb_en && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
      end
   end

   // Single compare process, mid-cycle while inputs and outputs are stable.
   always @(negedge clock) begin
      if (reset && chk_on) begin
         m_stall = model_stall();
         chk("ex_valid", 141'(ex_valid), 141'(m_valid));
         chk("ID_EX", ID_EX, m_idex);
         chk("stall", 141'(stall), 141'(m_stall));
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] w, input logic fl);
      if_valid = v;
      IF_ID    = {pc, w};
      flush    = fl;
   endtask

   logic [5:0]  ops [7] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F};
   logic [31:0] rw;
   logic        held;

   initial begin
      reset = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      drive(1'b1, 32'h0, r_ins(1, 1, 2), 1'b0);
      #12;
      chk("rst_ex_valid", 141'(ex_valid), 141'd0);
      chk("rst_ID_EX", ID_EX, 141'd0);
      chk("rst_stall", 141'(stall), 141'd0);
      @(posedge clock); #1;
      reset = 1'b1; chk_on = 1'b1;

      for (int i = 1; i < 32; i++) begin
         drive(1'b1, 32'(i * 4), r_ins(i, i, 1), 1'b0);
         cyc();
         chk("rf_init_rs", 141'(ID_EX[108:77]), 141'd0);
      end

      drive(1'b1, 32'h10, r_ins(3, 3, 5), 1'b0);
      wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h12345678;
      cyc();
      wb_en = 1'b0;
      chk("byp_rs", 141'(ID_EX[108:77]), 141'h12345678);
      chk("byp_rt", 141'(ID_EX[76:45]), 141'h12345678);
      chk("byp_dest", 141'(ID_EX[12:8]), 141'd5);
      chk("byp_ctrl", 141'(ID_EX[7:0]), 141'h80);
      chk("byp_pc", 141'(ID_EX[140:109]), 141'h10);

      drive(1'b1, 32'h14, i_ins(6'h23, 1, 2, 16'd4), 1'b0);
      cyc();
      chk("lw_ctrl", 141'(ID_EX[7:0]), 141'hD8);
      chk("lw_dest", 141'(ID_EX[12:8]), 141'd2);
      drive(1'b1, 32'h18, r_ins(2, 2, 4), 1'b0);
      #1 chk("lu_stall", 141'(stall), 141'd1);
      cyc();
      chk("lu_bubble_v", 141'(ex_valid), 141'd0);
      chk("lu_bubble", ID_EX, 141'd0);
      #1 chk("lu_nostall2", 141'(stall), 141'd0);
      cyc();
      chk("lu_issue_v", 141'(ex_valid), 141'd1);
      chk("lu_issue_dest", 141'(ID_EX[12:8]), 141'd4);

      drive(1'b1, 32'h1C, i_ins(6'h08, 0, 7, 16'hFFFF), 1'b0);
      cyc();
      chk("addi_imm", 141'(ID_EX[44:13]), 141'hFFFFFFFF);
      chk("addi_ctrl", 141'(ID_EX[7:0]), 141'h88);
      drive(1'b1, 32'h20, r_ins(0, 0, 1), 1'b0);
      wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEADBEEF;
      cyc();
      wb_en = 1'b0;
      chk("r0_byp", 141'(ID_EX[108:77]), 141'd0);
      cyc();
      chk("r0_read", 141'(ID_EX[108:77]), 141'd0);

      drive(1'b1, 32'h24, i_ins(6'h23, 1, 2, 16'd4), 1'b0);
      cyc();
      drive(1'b1, 32'h28, r_ins(2, 2, 4), 1'b1);
      #1 chk("fl_stall", 141'(stall), 141'd0);
      cyc();
      chk("fl_bubble", 141'(ex_valid), 141'd0);
      drive(1'b1, 32'h2C, 32'hFFFFFFFF, 1'b0);
      cyc();
      chk("ill_ctrl", 141'(ID_EX[7:0]), 141'h01);
      chk("ill_dest", 141'(ID_EX[12:8]), 141'd0);
      chk("ill_valid", 141'(ex_valid), 141'd1);

      drive(1'b1, 32'h30, i_ins(6'h23, 1, 2, 16'd4), 1'b0);
      cyc();
      drive(1'b1, 32'h34, r_ins(2, 2, 4), 1'b0);
      #1 chk("mr_stall", 141'(stall), 141'd1);
      #1 reset = 1'b0;
      #1;
      chk("mr_valid", 141'(ex_valid), 141'd0);
      chk("mr_idex", ID_EX, 141'd0);
      chk("mr_stall0", 141'(stall), 141'd0);
      reset = 1'b1;
      cyc();
      chk("mr_resume_v", 141'(ex_valid), 141'd1);
      chk("mr_resume_dest", 141'(ID_EX[12:8]), 141'd4);
      drive(1'b1, 32'h38, r_ins(3, 3, 5), 1'b0);
      cyc();
      chk("mr_rf_clr", 141'(ID_EX[108:77]), 141'd0);

      for (int n = 0; n < 3000; n++) begin
         @(negedge clock); #1;
         held = m_stall;
         @(posedge clock); #1;
         if (!held) begin
            rw = $urandom;
            rw[31:26] = ops[$urandom_range(0, 6)];
            if (rw[31:26] == 6'h3F) rw[31:26] = 6'($urandom);
            rw[25:21] = 5'($urandom_range(0, 7));
            rw[20:16] = 5'($urandom_range(0, 7));
            rw[15:11] = 5'($urandom_range(0, 7));
            if_valid = ($urandom_range(0, 7) != 0);
            IF_ID    = {$urandom, rw};
         end
         flush   = ($urandom_range(0, 7) == 0);
         wb_en   = $urandom_range(0, 1) == 1;
         wb_addr = 5'($urandom_range(0, 7));
         wb_data = $urandom;
      end
      @(negedge clock); #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
